// File: rtl/turn_signal_ctrl_if.sv
// Button inputs and light-FSM request outputs of the turn-signal front end.
// The master side (car body / bench) drives the raw buttons; the slave side
// (the controller) drives the latched requests, the mode and the step enable.
interface turn_signal_ctrl_if;
  logic       i_btn_l;
  logic       i_btn_r;
  logic       i_btn_h;
  logic       o_l;
  logic       o_r;
  logic       o_step;
  logic [1:0] o_mode;

  modport master (
    output i_btn_l, i_btn_r, i_btn_h,
    input  o_l, o_r, o_step, o_mode
  );

  modport slave (
    input  i_btn_l, i_btn_r, i_btn_h,
    output o_l, o_r, o_step, o_mode
  );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn-signal front end: synchronises and debounces the left/right/hazard
// buttons, turns debounced presses into a mode (IDLE/LEFT/RIGHT/HAZARD) with
// toggle and priority rules, and paces the downstream light FSM with a
// one-cycle step enable every DIV cycles, restarted on every mode change.
module turn_signal_ctrl #(
  parameter int DIV       = 25_000_000,  // clk cycles per step pulse, >= 2
  parameter int DB_CYCLES = 500_000      // stable cycles to accept a level, >= 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  turn_signal_ctrl_if.slave  bus
);

  localparam int P_W = $clog2(DIV);
  localparam int C_W = $clog2(DB_CYCLES) + 1;

  localparam logic [P_W-1:0] P_LAST = P_W'(DIV - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(DB_CYCLES - 1);

  // Button lane indices inside the 3-bit vectors below.
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_H = 2;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_e;

  logic [2:0]     w_btn_raw;
  logic [2:0]     r_sync1;
  logic [2:0]     r_sync2;
  logic [2:0]     r_db_lvl;
  logic [C_W-1:0] r_db_cnt [3];
  logic [2:0]     r_press;

  mode_e          r_mode;
  mode_e          w_mode_nxt;
  logic           w_mode_chg;
  logic           r_l;
  logic           r_r;

  logic [P_W-1:0] r_presc;
  logic           r_step;

  assign w_btn_raw = {bus.i_btn_h, bus.i_btn_r, bus.i_btn_l};

  // Two-flop synchroniser per raw button.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: accept a new level after DB_CYCLES stable cycles and
  // emit a one-cycle press pulse when the accepted level rises.
  // NOTE: the counter array is small control state, not a RAM, so it is reset
  // like any other register; a held button must re-qualify after reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_db_lvl <= '0;
      r_press  <= '0;
      for (int i = 0; i < 3; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == C_LAST) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
          r_press[i]  <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + C_W'(1);
        end
      end
    end
  end

  // Next-mode decode: hazard beats left beats right; only the winner acts.
  // NOTE: the default assignment first keeps this purely combinational; a path
  // that left w_mode_nxt unassigned would infer a latch.
  always_comb begin
    w_mode_nxt = r_mode;
    if (r_press[BTN_H]) begin
      w_mode_nxt = (r_mode == MODE_HAZARD) ? MODE_IDLE : MODE_HAZARD;
    end else if (r_press[BTN_L]) begin
      case (r_mode)
        MODE_IDLE, MODE_RIGHT: w_mode_nxt = MODE_LEFT;
        MODE_LEFT:             w_mode_nxt = MODE_IDLE;
        default:               w_mode_nxt = r_mode;  // hazard ignores L
      endcase
    end else if (r_press[BTN_R]) begin
      case (r_mode)
        MODE_IDLE, MODE_LEFT: w_mode_nxt = MODE_RIGHT;
        MODE_RIGHT:           w_mode_nxt = MODE_IDLE;
        default:              w_mode_nxt = r_mode;   // hazard ignores R
      endcase
    end
  end

  assign w_mode_chg = (w_mode_nxt != r_mode);

  // Mode register with L/R requests registered from the next-mode value so
  // they change on the same edge as the mode itself.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode <= MODE_IDLE;
      r_l    <= 1'b0;
      r_r    <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_l    <= (w_mode_nxt == MODE_LEFT)  || (w_mode_nxt == MODE_HAZARD);
      r_r    <= (w_mode_nxt == MODE_RIGHT) || (w_mode_nxt == MODE_HAZARD);
    end
  end

  // Step prescaler: free-running in every mode, restarted (and its pending
  // wrap suppressed) on any mode change so the light pattern starts cleanly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_step  <= 1'b0;
    end else if (w_mode_chg) begin
      r_presc <= '0;
      r_step  <= 1'b0;
    end else if (r_presc == P_LAST) begin
      r_presc <= '0;
      r_step  <= 1'b1;
    end else begin
      r_presc <= r_presc + P_W'(1);
      r_step  <= 1'b0;
    end
  end

  assign bus.o_l    = r_l;
  assign bus.o_r    = r_r;
  assign bus.o_step = r_step;
  assign bus.o_mode = r_mode;

endmodule

// File: doc/turn_signal_ctrl.md
# turn_signal_ctrl

Front-end controller for the tail-light sequencer. Converts three raw push-buttons (left, right, hazard) into the latched L/R request levels the light FSM consumes. Generates the Step clock-enable that paces the light FSM: the FSM advances only on cycles with Step=1. Contains per-button synchronisation and debounce, a mode FSM with toggle and priority rules, and a step prescaler.

## Interface
- DIV, 25_000_000: Clk cycles per Step pulse; legal range ≥2.
- DB_CYCLES, 500_000: consecutive stable synchronised cycles needed to accept a button level change; legal range ≥1.
- Clk  in  1  system clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- BtnL  in  1  raw left button, asynchronous, active-high.
- BtnR  in  1  raw right button, asynchronous, active-high.
- BtnH  in  1  raw hazard button, asynchronous, active-high.
- L  out  1  left request to the light FSM, registered.
- R  out  1  right request to the light FSM, registered.
- Step  out  1  one-cycle advance enable for the light FSM, registered.
- Mode  out  2  current mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

## Operation
- Reset clears everything: Mode=IDLE, L=0, R=0, Step=0; synchronisers, debounced levels, press pulses, debounce counters and prescaler all 0.
- Synchroniser: each button passes through a 2-flop synchroniser, giving s.
- Debounce, per button: a stable level d and counter c.
  - s==d: c←0.
  - s≠d and c==DB_CYCLES-1: d←s and c←0; if the new d is 1, press←1 for one cycle.
  - Otherwise: c←c+1.
  - press is 0 on all other cycles. Release (d 1→0) generates no event.
- Mode FSM. Only press pulses are used. With simultaneous pulses, priority is H > L > R and only the winner is acted on.
  - H press: HAZARD→IDLE; any other mode→HAZARD.
  - L press: IDLE/RIGHT→LEFT; LEFT→IDLE; HAZARD: ignored.
  - R press: IDLE/LEFT→RIGHT; RIGHT→IDLE; HAZARD: ignored.
- Outputs, registered from the next-mode value:
  - L=1 in LEFT or HAZARD.
  - R=1 in RIGHT or HAZARD.
  - Mode mirrors the mode register.
- Prescaler: counter p runs in all modes, including IDLE, so the light FSM can return to its rest state.
  - p==DIV-1: p←0 and Step←1.
  - Otherwise: p←p+1 and Step←0.
  - On any edge where Mode changes: p←0 and Step←0. This override beats the wrap.

## Timing
- Raw press to Mode/L/R change:
  - Synchroniser: 2 edges.
  - Debounce accept plus press pulse: DB_CYCLES edges.
  - Mode update: 1 edge.
  - Total: DB_CYCLES+3 edges, provided the button stays high throughout.
- Glitches shorter than DB_CYCLES synchronised cycles are rejected. A bounce resets c to 0.
- Mode change at edge E: first Step is high in the cycle after edge E+DIV. Later Steps follow every DIV cycles, each exactly one cycle wide.
- Holding a button produces one press only. A new toggle needs a debounced release, then a debounced press.
- Asynchronous Rst mid-operation:
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - After deassertion, a still-held button's debounced level rises from 0, so it counts as a fresh press.
- Counter widths: $clog2(DIV) and $clog2(DB_CYCLES)+1. No overflow is possible.

## Test plan
All scenarios use DIV=8, DB_CYCLES=4.
- Reset: assert Rst asynchronously mid-cycle → L=R=Step=0 and Mode=00 immediately; hold for 3 edges, then release → Step first high at edge 8 after release.
- Left toggle: BtnL high from edge 0 and held → Mode=01, L=1, R=0 after edge 7; Step pulses after edges 15 and 23. Release, wait 10 cycles, press again → Mode=00, L=0.
- Bounce filter: BtnL toggles high/low every 2 cycles for 20 cycles, then stays low → Mode stays 00 and no press pulse occurs.
- Priority: BtnL, BtnR and BtnH rise on the same cycle → Mode=11 (L=R=1) after 7 edges. Second H press → Mode=00.
- Hazard lockout: in HAZARD, press BtnL, then BtnR, each debounced → Mode stays 11 and the prescaler phase is not reset.
- Direction switch: in LEFT, press BtnR → Mode goes straight to 10 (L=0, R=1) with no IDLE cycle; p restarts and the next Step is 8 edges later.
